// File: rtl/spwm_if.sv
// Control, index and gate-drive bundle for the SPWM sequencer.
// The master side drives commands and comparator bits; the slave side drives gates.
interface spwm_if #(
  parameter int WIDTH = 12
);
  logic             start;
  logic             stop;
  logic             fault_in;
  logic             clear_fault;
  logic [WIDTH-1:0] m_target;
  logic             carrier_peak;
  logic             raw_a;
  logic             raw_b;
  logic             raw_c;
  logic [WIDTH-1:0] m_index;
  logic             gate_ah;
  logic             gate_al;
  logic             gate_bh;
  logic             gate_bl;
  logic             gate_ch;
  logic             gate_cl;
  logic [2:0]       state;
  logic             fault_latched;

  modport master (
    output start, stop, fault_in, clear_fault,
    output m_target, carrier_peak,
    output raw_a, raw_b, raw_c,
    input  m_index, state, fault_latched,
    input  gate_ah, gate_al, gate_bh,
    input  gate_bl, gate_ch, gate_cl
  );

  modport slave (
    input  start, stop, fault_in, clear_fault,
    input  m_target, carrier_peak,
    input  raw_a, raw_b, raw_c,
    output m_index, state, fault_latched,
    output gate_ah, gate_al, gate_bh,
    output gate_bl, gate_ch, gate_cl
  );
endinterface

// File: rtl/spwm_sequencer.sv
// Run/fault sequencer for 3-phase SPWM: precharge, soft ramp, stop, fault.
// Conditions comparator outputs into complementary gates with dead time.
module spwm_sequencer #(
  parameter int WIDTH            = 12,
  parameter int DEADTIME         = 8,
  parameter int PRECHARGE_CYCLES = 1024,
  parameter int RAMP_STEP        = 16
) (
  input logic  clk,
  input logic  rst_n,
  spwm_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_RAMP  = 3'd2,
    S_RUN   = 3'd3,
    S_STOP  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam int PW =
    (PRECHARGE_CYCLES > 1) ? $clog2(PRECHARGE_CYCLES) : 1;
  localparam int CW =
    (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  localparam logic [WIDTH-1:0] STEP = WIDTH'(RAMP_STEP);
  localparam logic [PW-1:0] PRE_LOAD = PW'(PRECHARGE_CYCLES - 1);
  localparam logic [CW-1:0] DT_LOAD = CW'(DEADTIME);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             f_meta, fault_s;

  logic [WIDTH-1:0] toward, down;
  logic [2:0]       raw, req, prev, gh, gl;
  logic [CW-1:0]    cnt [3];
  logic             forced;

  // Slew-limited step toward the target; never passes it.
  function automatic logic [WIDTH-1:0] slew(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] tgt
  );
    logic [WIDTH-1:0] d;
    if (cur < tgt) begin
      d = tgt - cur;
      return cur + ((d > STEP) ? STEP : d);
    end else begin
      d = cur - tgt;
      return cur - ((d > STEP) ? STEP : d);
    end
  endfunction

  assign toward = slew(idx_q, bus.m_target);
  assign down   = idx_q - ((idx_q > STEP) ? STEP : idx_q);

  // Two-flop synchroniser for the external fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_meta  <= 1'b0;
      fault_s <= 1'b0;
    end else begin
      f_meta  <= bus.fault_in;
      fault_s <= f_meta;
    end
  end

  // Next state, index and precharge count; fault overrides everything.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pcnt_d  = pcnt_q;
    if (fault_s) begin
      state_d = S_FAULT;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          idx_d = '0;
          if (bus.start && !bus.stop) begin
            state_d = S_PRE;
            pcnt_d  = PRE_LOAD;
          end
        end
        S_PRE: begin
          if (bus.stop)
            state_d = S_STOP;
          else if (pcnt_q == '0)
            state_d = S_RAMP;
          else
            pcnt_d = pcnt_q - 1'b1;
        end
        S_RAMP: begin
          if (bus.stop) begin
            state_d = S_STOP;
          end else if (bus.carrier_peak) begin
            idx_d = toward;
            if (toward == bus.m_target)
              state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (bus.stop)
            state_d = S_STOP;
          else if (bus.carrier_peak)
            idx_d = toward;
        end
        S_STOP: begin
          if (bus.carrier_peak) begin
            idx_d = down;
            if (down == '0)
              state_d = S_IDLE;
          end
        end
        S_FAULT: begin
          idx_d = '0;
          if (bus.clear_fault)
            state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign raw = {bus.raw_c, bus.raw_b, bus.raw_a};

  // Precharge asks for low sides; active states pass comparators.
  always_comb begin
    req = '0;
    if (state_q == S_RAMP || state_q == S_RUN ||
        state_q == S_STOP)
      req = raw;
  end

  // Off when sitting in, or about to enter, IDLE or FAULT.
  assign forced = (state_q == S_IDLE) ||
                  (state_q == S_FAULT) ||
                  (state_d == S_IDLE) ||
                  (state_d == S_FAULT);

  // Per-phase dead-time unit; any request change restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
      gh   <= '0;
      gl   <= '0;
      for (int p = 0; p < 3; p++)
        cnt[p] <= DT_LOAD;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (forced) begin
          gh[p]   <= 1'b0;
          gl[p]   <= 1'b0;
          cnt[p]  <= DT_LOAD;
          prev[p] <= 1'b0;
        end else if (req[p] != prev[p]) begin
          gh[p]   <= 1'b0;
          gl[p]   <= 1'b0;
          cnt[p]  <= DT_LOAD;
          prev[p] <= req[p];
        end else if (cnt[p] != '0) begin
          gh[p]   <= 1'b0;
          gl[p]   <= 1'b0;
          cnt[p]  <= cnt[p] - 1'b1;
        end else begin
          gh[p]   <= req[p];
          gl[p]   <= ~req[p];
        end
      end
    end
  end

  assign bus.m_index       = idx_q;
  assign bus.state         = state_q;
  assign bus.fault_latched = (state_q == S_FAULT);
  assign bus.gate_ah       = gh[0];
  assign bus.gate_al       = gl[0];
  assign bus.gate_bh       = gh[1];
  assign bus.gate_bl       = gl[1];
  assign bus.gate_ch       = gh[2];
  assign bus.gate_cl       = gl[2];

endmodule

// File: tb/tb_spwm_sequencer.sv
// Directed bench for spwm_sequencer: start-up, dead time, slew,
// fault, stop and async reset, with hand-computed expectations.
module tb_spwm_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  spwm_if #(.WIDTH(12)) bus ();

  spwm_sequencer #(
    .WIDTH(12),
    .DEADTIME(8),
    .PRECHARGE_CYCLES(1024),
    .RAMP_STEP(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  function automatic logic [5:0] gv();
    return {bus.gate_ah, bus.gate_al,
            bus.gate_bh, bus.gate_bl,
            bus.gate_ch, bus.gate_cl};
  endfunction

  // High and low side of a phase must never be on together.
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if ((bus.gate_ah & bus.gate_al) |
          (bus.gate_bh & bus.gate_bl) |
          (bus.gate_ch & bus.gate_cl)) begin
        n_err++;
        $display("FAIL shoot_through got=%b want=no pair", gv());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peak(input int gap);
    bus.carrier_peak = 1'b0;
    repeat (gap - 1) tick();
    bus.carrier_peak = 1'b1;
    tick();
    bus.carrier_peak = 1'b0;
  endtask

  task automatic test_reset();
    bus.start        = 1'b0;
    bus.stop         = 1'b0;
    bus.fault_in     = 1'b0;
    bus.clear_fault  = 1'b0;
    bus.m_target     = '0;
    bus.carrier_peak = 1'b0;
    bus.raw_a        = 1'b0;
    bus.raw_b        = 1'b0;
    bus.raw_c        = 1'b0;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if (bus.state !== 3'd0) begin
      n_err++;
      $display("FAIL rst_state got=%0d want=0", bus.state);
    end
    n_cmp++;
    if (bus.m_index !== 12'd0) begin
      n_err++;
      $display("FAIL rst_index got=%0d want=0", bus.m_index);
    end
    n_cmp++;
    if (gv() !== 6'b0) begin
      n_err++;
      $display("FAIL rst_gates got=%b want=000000", gv());
    end
    n_cmp++;
    if (bus.fault_latched !== 1'b0) begin
      n_err++;
      $display("FAIL rst_latch got=%b want=0", bus.fault_latched);
    end
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();
  endtask

  task automatic test_start_ramp();
    bus.m_target = 12'd2048;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if (bus.state !== 3'd1) begin
      n_err++;
      $display("FAIL pre_enter got=%0d want=1", bus.state);
    end
    for (int i = 1; i <= 1023; i++) begin
      tick();
      if (i == 8) begin
        n_cmp++;
        if (gv() !== 6'b0) begin
          n_err++;
          $display("FAIL pre_c8 got=%b want=000000", gv());
        end
      end
      if (i == 9) begin
        n_cmp++;
        if (gv() !== 6'b010101) begin
          n_err++;
          $display("FAIL pre_c9 got=%b want=010101", gv());
        end
      end
    end
    n_cmp++;
    if (bus.state !== 3'd1) begin
      n_err++;
      $display("FAIL pre_last got=%0d want=1", bus.state);
    end
    tick();
    n_cmp++;
    if (bus.state !== 3'd2) begin
      n_err++;
      $display("FAIL ramp_enter got=%0d want=2", bus.state);
    end
    for (int k = 1; k <= 128; k++) begin
      peak(100);
      if (k == 1) begin
        n_cmp++;
        if (bus.m_index !== 12'd16) begin
          n_err++;
          $display("FAIL ramp_p1 got=%0d want=16", bus.m_index);
        end
      end
      if (k == 127) begin
        n_cmp++;
        if (bus.m_index !== 12'd2032 || bus.state !== 3'd2) begin
          n_err++;
          $display("FAIL ramp_p127 got=%0d/%0d want=2032/2",
                   bus.m_index, bus.state);
        end
      end
    end
    n_cmp++;
    if (bus.m_index !== 12'd2048 || bus.state !== 3'd3) begin
      n_err++;
      $display("FAIL ramp_done got=%0d/%0d want=2048/3",
               bus.m_index, bus.state);
    end
  endtask

  task automatic test_dead_time();
    logic seen;
    bus.raw_a = 1'b1;
    tick();
    n_cmp++;
    if ({bus.gate_ah, bus.gate_al} !== 2'b00) begin
      n_err++;
      $display("FAIL dt_k got=%b%b want=00",
               bus.gate_ah, bus.gate_al);
    end
    repeat (8) tick();
    n_cmp++;
    if (bus.gate_ah !== 1'b0) begin
      n_err++;
      $display("FAIL dt_k8 got=%b want=0", bus.gate_ah);
    end
    tick();
    n_cmp++;
    if ({bus.gate_ah, bus.gate_al} !== 2'b10) begin
      n_err++;
      $display("FAIL dt_k9 got=%b%b want=10",
               bus.gate_ah, bus.gate_al);
    end
    seen = 1'b0;
    bus.raw_b = 1'b1;
    repeat (5) begin
      tick();
      seen |= bus.gate_bh;
    end
    bus.raw_b = 1'b0;
    repeat (20) begin
      tick();
      seen |= bus.gate_bh;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL dt_pulse got=%b want=0", seen);
    end
    n_cmp++;
    if (bus.gate_bl !== 1'b1) begin
      n_err++;
      $display("FAIL dt_bl got=%b want=1", bus.gate_bl);
    end
    bus.raw_a = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_target_change();
    bus.m_target = 12'd1000;
    for (int k = 1; k <= 66; k++) begin
      peak(4);
      if (k == 65) begin
        n_cmp++;
        if (bus.m_index !== 12'd1008) begin
          n_err++;
          $display("FAIL tc_p65 got=%0d want=1008", bus.m_index);
        end
      end
    end
    n_cmp++;
    if (bus.m_index !== 12'd1000) begin
      n_err++;
      $display("FAIL tc_1000 got=%0d want=1000", bus.m_index);
    end
    peak(4);
    n_cmp++;
    if (bus.m_index !== 12'd1000 || bus.state !== 3'd3) begin
      n_err++;
      $display("FAIL tc_hold got=%0d/%0d want=1000/3",
               bus.m_index, bus.state);
    end
    bus.m_target = 12'd1400;
    repeat (10) peak(4);
    n_cmp++;
    if (bus.m_index !== 12'd1160) begin
      n_err++;
      $display("FAIL tc_up got=%0d want=1160", bus.m_index);
    end
    bus.m_target = 12'd1010;
    for (int k = 1; k <= 10; k++) begin
      peak(4);
      if (k == 9) begin
        n_cmp++;
        if (bus.m_index !== 12'd1016) begin
          n_err++;
          $display("FAIL tc_p9 got=%0d want=1016", bus.m_index);
        end
      end
    end
    n_cmp++;
    if (bus.m_index !== 12'd1010) begin
      n_err++;
      $display("FAIL tc_1010 got=%0d want=1010", bus.m_index);
    end
    peak(4);
    n_cmp++;
    if (bus.m_index !== 12'd1010) begin
      n_err++;
      $display("FAIL tc_nover got=%0d want=1010", bus.m_index);
    end
  endtask

  task automatic test_fault();
    bus.raw_c = 1'b1;
    repeat (12) tick();
    bus.fault_in = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus.state !== 3'd3) begin
      n_err++;
      $display("FAIL flt_e2 got=%0d want=3", bus.state);
    end
    tick();
    n_cmp++;
    if (gv() !== 6'b0 || bus.m_index !== 12'd0) begin
      n_err++;
      $display("FAIL flt_e3 got=%b/%0d want=000000/0",
               gv(), bus.m_index);
    end
    n_cmp++;
    if (bus.state !== 3'd5 || bus.fault_latched !== 1'b1) begin
      n_err++;
      $display("FAIL flt_st got=%0d/%b want=5/1",
               bus.state, bus.fault_latched);
    end
    bus.clear_fault = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (bus.state !== 3'd5) begin
      n_err++;
      $display("FAIL flt_clr_early got=%0d want=5", bus.state);
    end
    bus.clear_fault = 1'b0;
    bus.fault_in = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (bus.state !== 3'd5) begin
      n_err++;
      $display("FAIL flt_hold got=%0d want=5", bus.state);
    end
    bus.clear_fault = 1'b1;
    tick();
    bus.clear_fault = 1'b0;
    n_cmp++;
    if (bus.state !== 3'd0 || bus.fault_latched !== 1'b0) begin
      n_err++;
      $display("FAIL flt_clr got=%0d/%b want=0/0",
               bus.state, bus.fault_latched);
    end
    bus.raw_c = 1'b0;
  endtask

  task automatic test_stop();
    bus.m_target = 12'd40;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (1024) tick();
    n_cmp++;
    if (bus.state !== 3'd2) begin
      n_err++;
      $display("FAIL stp_ramp got=%0d want=2", bus.state);
    end
    repeat (3) peak(4);
    n_cmp++;
    if (bus.state !== 3'd3 || bus.m_index !== 12'd40) begin
      n_err++;
      $display("FAIL stp_run got=%0d/%0d want=3/40",
               bus.state, bus.m_index);
    end
    bus.stop = 1'b1;
    tick();
    n_cmp++;
    if (bus.state !== 3'd4) begin
      n_err++;
      $display("FAIL stp_enter got=%0d want=4", bus.state);
    end
    bus.start = 1'b1;
    peak(4);
    n_cmp++;
    if (bus.m_index !== 12'd24) begin
      n_err++;
      $display("FAIL stp_24 got=%0d want=24", bus.m_index);
    end
    peak(4);
    n_cmp++;
    if (bus.m_index !== 12'd8 || bus.state !== 3'd4) begin
      n_err++;
      $display("FAIL stp_8 got=%0d/%0d want=8/4",
               bus.m_index, bus.state);
    end
    peak(4);
    n_cmp++;
    if (bus.m_index !== 12'd0 || bus.state !== 3'd0) begin
      n_err++;
      $display("FAIL stp_0 got=%0d/%0d want=0/0",
               bus.m_index, bus.state);
    end
    n_cmp++;
    if (gv() !== 6'b0) begin
      n_err++;
      $display("FAIL stp_gates got=%b want=000000", gv());
    end
    tick();
    n_cmp++;
    if (bus.state !== 3'd0) begin
      n_err++;
      $display("FAIL stp_idle got=%0d want=0", bus.state);
    end
    bus.start = 1'b0;
    bus.stop = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    bus.m_target = 12'd2048;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (1024) tick();
    repeat (3) peak(4);
    n_cmp++;
    if (bus.m_index !== 12'd48 || gv() !== 6'b010101) begin
      n_err++;
      $display("FAIL ar_pre got=%0d/%b want=48/010101",
               bus.m_index, gv());
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.state !== 3'd0 || bus.m_index !== 12'd0) begin
      n_err++;
      $display("FAIL ar_st got=%0d/%0d want=0/0",
               bus.state, bus.m_index);
    end
    n_cmp++;
    if (gv() !== 6'b0 || bus.fault_latched !== 1'b0) begin
      n_err++;
      $display("FAIL ar_out got=%b/%b want=000000/0",
               gv(), bus.fault_latched);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_start_ramp();
    test_dead_time();
    test_target_change();
    test_fault();
    test_stop();
    test_async_reset();
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spwm_sequencer.md
Name: spwm_sequencer

Overview:
- Run/fault controller and gate conditioner for the 3-phase sine-triangle PWM datapath.
- Sequences start-up: bootstrap precharge, then a soft ramp of the modulation index fed to the sine generator's amplitude scaling.
- Takes the raw comparator outputs and produces complementary high/low gate drives with dead-time insertion.
- Handles controlled stop and latched fault shutdown.

Parameters:
- WIDTH, 12, width of the modulation index and target; matches the sine/carrier word width.
- DEADTIME, 8, clock cycles of counter load for the both-off interval (total both-off time = DEADTIME+1 cycles).
- PRECHARGE_CYCLES, 1024, cycles that the low-side switches are held on in PRECHARGE.
- RAMP_STEP, 16, index change applied per carrier-peak pulse.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; requests a run from IDLE.
- stop  input  1  level; requests a controlled ramp-down.
- fault_in  input  1  asynchronous external fault, active-high.
- clear_fault  input  1  leaves FAULT when the fault is gone.
- m_target  input  WIDTH  requested modulation index.
- carrier_peak  input  1  one-cycle pulse at the triangle maximum; the index updates only on this pulse.
- raw_a, raw_b, raw_c  input  1 each  comparator outputs (1 = high side on).
- m_index  output  WIDTH  modulation index to the sine generator.
- gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl  output  1 each  gate drives.
- state  output  3  IDLE=0, PRECHARGE=1, RAMP=2, RUN=3, STOPPING=4, FAULT=5.
- fault_latched  output  1  high while in FAULT.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, m_index=0, all gates 0, fault_latched=0.
  - Fault synchroniser cleared; PRECHARGE counter 0; every phase dead-time counter = DEADTIME; every phase previous-request register = 0.
- fault_in passes through a 2-flop synchroniser (fault_s). Priority, highest first: fault_s, then stop, then start.
- IDLE:
  - Gates forced 0, m_index=0.
  - start=1 and stop=0 -> PRECHARGE, load counter with PRECHARGE_CYCLES-1.
- PRECHARGE:
  - Phase requests forced to 0, so the low sides turn on after dead time.
  - Counter decrements each cycle; at 0 -> RAMP.
  - stop=1 -> STOPPING.
  - start is ignored.
- RAMP / RUN / STOPPING:
  - Phase requests = raw_x.
  - m_index updates only on cycles with carrier_peak=1.
- RAMP, on each carrier_peak:
  - If m_index < m_target: m_index += min(RAMP_STEP, m_target-m_index).
  - If m_index > m_target: m_index -= min(RAMP_STEP, m_index-m_target).
  - When m_index == m_target after the update (or already equal) -> RUN.
  - stop=1 -> STOPPING.
- RUN:
  - m_index tracks m_target with the same slew-limited rule; m_target changes never step the index by more than RAMP_STEP per peak.
  - stop=1 -> STOPPING.
- STOPPING:
  - On each carrier_peak, m_index -= min(RAMP_STEP, m_index).
  - When m_index == 0 at a carrier_peak -> IDLE.
  - start is ignored.
- FAULT:
  - Entered from any state on the cycle fault_s=1.
  - m_index <= 0; gates forced 0 on the same edge, giving at most 3 clk edges from fault_in to gates low.
  - fault_latched=1. Stays in FAULT while fault_s=1.
  - clear_fault=1 and fault_s=0 -> IDLE. clear_fault while fault_s=1 is ignored.
- Dead-time unit, per phase, all outputs registered:
  - Forced off (IDLE, FAULT): gates 0; cnt <= DEADTIME; prev <= 0.
  - Otherwise, if req != prev: gates <= 0, cnt <= DEADTIME, prev <= req.
  - Otherwise, if cnt != 0: gates <= 0, cnt <= cnt-1.
  - Otherwise: gate_xh <= req, gate_xl <= ~req.
  - A request edge sampled at edge k gives gates low after edge k and the new side on after edge k+DEADTIME+1.
  - A request that toggles again before expiry reloads cnt, so pulses of DEADTIME cycles or fewer never reach a gate.
  - gate_xh and gate_xl are never both 1. This is an invariant in all states, including reset and fault.
- Arithmetic: all index math is unsigned WIDTH-bit, with no wrap at 0 or 2^WIDTH-1.

Test Plan:
- Reset and start: m_target=2048, start=1, carrier_peak every 100 cycles, PRECHARGE_CYCLES=1024 -> state=1 for exactly 1024 cycles with gate_xl=1 from cycle 9. Then RAMP, with m_index 16, 32, … reaching 2048 on the 128th peak -> RUN.
- Dead time: in RUN, raw_a 0->1 sampled at edge k -> gate_al=0 after edge k, gate_ah=1 after edge k+9. A raw_b 5-cycle high pulse -> gate_bh never 1.
- Fault: fault_in=1 at any time in RUN -> all gates 0 within 3 edges, m_index=0, state=5. clear_fault while fault_in=1 -> stays 5. After fault_in=0, clear_fault -> IDLE.
- Stop: RUN at m_index=40, stop=1 -> peaks give 24, 8, 0, then state=0 with gates 0. start asserted during STOPPING is ignored.
- Target change: in RUN at 2048, m_target=1000 -> m_index falls by 16 per peak and ends exactly at 1000. m_target=1010 set mid-slew -> no overshoot.
- Async reset mid-RAMP: rst_n low asynchronously -> all outputs 0 and state=0 before the next clk edge.
